// File: rtl/ring_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// State codes are plain 2-bit constants so external checkers can compare against them directly.
package ring_meter_pkg;

    localparam int DEF_GATE_W      = 16;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } meter_state_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Largest value representable in w bits, used as the accumulator ceiling.
    function automatic logic [63:0] sat_max(input int w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/ring_freq_meter_sync_edge_det.sv
// Brings the asynchronous oscillator tap into the clk domain and flags its rising edges.
// The history flop runs every cycle so a window never starts on a stale comparison.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/ring_freq_meter.sv
// Counts synchronized oscillator rising edges over a window of gate_cycles clk cycles.
// Handshake: start is sampled only while idle; busy covers ARM..DONE; done pulses once with count/overflow.
module ring_freq_meter
    import ring_meter_pkg::*;
#(
    parameter int GATE_W      = DEF_GATE_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              osc_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [GATE_W-1:0] g;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_nxt;
    logic              ovf;
    logic              ovf_nxt;
    logic              osc_level;
    logic              osc_rise;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(osc_in),
        .level   (osc_level),
        .rise    (osc_rise)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                acc_nxt   = '0;
                ovf_nxt   = 1'b0;
                state_nxt = (g == '0) ? ST_DONE : ST_MEASURE;
            end
            ST_MEASURE: begin
                // Saturate rather than wrap; a rise that cannot be counted marks the window.
                if (osc_rise) begin
                    if (acc == CNT_MAX) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        acc_nxt = acc + CNT_W'(1);
                    end
                end
                if (g == GATE_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            g        <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            if (state == ST_IDLE && start) begin
                g <= gate_cycles;
            end else if (state == ST_MEASURE) begin
                g <= g - GATE_W'(1);
            end
            // Results are captured on entry to DONE so they are already valid while done is high.
            done <= (state_nxt == ST_DONE);
            if (state_nxt == ST_DONE) begin
                count    <= acc_nxt;
                overflow <= ovf_nxt;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed and randomized checks of ring_freq_meter against an edge-counting reference model.
module tb_ring_freq_meter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        osc_in = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] gate_a = '0;
    logic [15:0] gate_b = '0;
    logic        busy_a, done_a, ovf_a;
    logic [15:0] count_a;
    logic        busy_b, done_b, ovf_b;
    logic [3:0]  count_b;

    int checks = 0;
    int errors = 0;

    bit osc_log[$];
    int osc_mode  = 0;
    bit osc_level = 1'b0;
    int osc_hp    = 4;
    int osc_ph    = 0;

    ring_freq_meter #(.GATE_W(16), .CNT_W(16), .SYNC_STAGES(S)) dut_a (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start_a), .gate_cycles(gate_a),
        .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a)
    );

    ring_freq_meter #(.GATE_W(16), .CNT_W(4), .SYNC_STAGES(S)) dut_b (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start_b), .gate_cycles(gate_b),
        .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    // Every posedge records what the DUT synchronizers sample.
    always @(posedge clk) osc_log.push_back(osc_in);

    always @(negedge clk) begin
        case (osc_mode)
            1: begin
                osc_ph++;
                if (osc_ph >= osc_hp) begin
                    osc_ph = 0;
                    osc_in = ~osc_in;
                end
            end
            2: osc_in = 1'($urandom_range(0, 1));
            default: osc_in = osc_level;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rises of the synchronized level seen in the G cycles following the ARM cycle.
    function automatic int model_raw(input int e, input int g);
        int n = 0;
        for (int j = e + 1; j <= e + g; j++) begin
            if (osc_log[j-S+1] && !osc_log[j-S]) n++;
        end
        return n;
    endfunction

    task automatic measure(input string tag, input bit sel, input int g, input int poke);
        int e, busy_n, done_n, done_i, raw, mx;
        logic [31:0] cnt_done, ovf_done, exp_cnt, exp_ovf;
        bit fin, b, d;
        @(negedge clk);
        e = osc_log.size();
        if (sel) begin start_b = 1'b1; gate_b = 16'(g); end
        else     begin start_a = 1'b1; gate_a = 16'(g); end
        busy_n = 0; done_n = 0; done_i = -1; fin = 1'b0;
        cnt_done = '1; ovf_done = '1;
        for (int i = 0; i < g + 20; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (i == poke) begin
                if (sel) begin start_b = 1'b1; gate_b = 16'd8; end
                else     begin start_a = 1'b1; gate_a = 16'd8; end
            end
            b = sel ? busy_b : busy_a;
            d = sel ? done_b : done_a;
            if (d) begin
                done_n++;
                done_i   = i;
                cnt_done = sel ? 32'(count_b) : 32'(count_a);
                ovf_done = sel ? 32'(ovf_b) : 32'(ovf_a);
            end
            if (b) busy_n++;
            else begin
                fin = 1'b1;
                break;
            end
        end
        raw     = model_raw(e, g);
        mx      = sel ? 15 : 65535;
        exp_cnt = (raw > mx) ? mx : raw;
        exp_ovf = (raw > mx) ? 1 : 0;
        chk({tag, "_finished"}, 32'(fin), 1);
        chk({tag, "_busy_len"}, busy_n, g + 2);
        chk({tag, "_done_cnt"}, done_n, 1);
        chk({tag, "_done_pos"}, done_i, g + 1);
        chk({tag, "_count"}, cnt_done, exp_cnt);
        chk({tag, "_overflow"}, ovf_done, exp_ovf);
        chk({tag, "_count_hold"}, sel ? 32'(count_b) : 32'(count_a), exp_cnt);
    endtask

    initial begin
        int g, sel, dn;
        repeat (3) @(negedge clk);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_count_a", 32'(count_a), 0);
        chk("rst_ovf_a", 32'(ovf_a), 0);
        chk("rst_busy_b", 32'(busy_b), 0);
        chk("rst_count_b", 32'(count_b), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        osc_mode = 1; osc_hp = 4;
        repeat (8) @(negedge clk);
        measure("p8_g64", 1'b0, 64, -1);
        chk("p8_g64_is8", 32'(count_a), 8);

        osc_mode = 0; osc_level = 1'b0;
        repeat (6) @(negedge clk);
        measure("low_g100", 1'b0, 100, -1);
        osc_level = 1'b1;
        repeat (6) @(negedge clk);
        measure("high_g100", 1'b0, 100, -1);

        osc_mode = 1; osc_hp = 3;
        measure("pre_zero", 1'b0, 40, -1);
        measure("gate_zero", 1'b0, 0, -1);

        osc_hp = 2;
        measure("sat_g64", 1'b1, 64, -1);
        measure("sat_g16", 1'b1, 16, -1);

        osc_hp = 4;
        measure("poke_g64", 1'b0, 64, 20);

        @(negedge clk);
        start_a = 1'b1; gate_a = 16'd64;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_a), 0);
        chk("arst_count", 32'(count_a), 0);
        chk("arst_ovf", 32'(ovf_a), 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) dn++;
        end
        chk("arst_no_done", dn, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        measure("after_rst", 1'b0, 50, -1);

        for (int k = 0; k < 8; k++) begin
            osc_mode  = $urandom_range(0, 2);
            osc_hp    = $urandom_range(1, 6);
            osc_level = 1'($urandom_range(0, 1));
            g         = $urandom_range(0, 150);
            sel       = $urandom_range(0, 1);
            repeat ($urandom_range(1, 5)) @(negedge clk);
            measure($sformatf("rnd%0d", k), 1'(sel), g, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_freq_meter.md
Name: ring_freq_meter

Overview:
- Reader side of the ring-oscillator/divider chain: measures the divided oscillator output (e.g. the /128 tap) against the system clock.
- Synchronizes the asynchronous slow clock, detects its rising edges, and counts them over a programmable gate window of system-clock cycles.
- Result is reported through a start/busy/done handshake, so firmware or a test harness can read oscillator frequency as edges per window.

Parameters:
- GATE_W, 16, width of gate-window length input (window = gate_cycles clk cycles).
- CNT_W, 16, width of edge count result.
- SYNC_STAGES, 2, number of synchronizer flops on osc_in (min 2).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, asynchronous, active-high; all state cleared immediately on assertion.
- osc_in  input  1  divided oscillator clock, asynchronous to clk; treated as data.
- start  input  1  request a measurement; sampled only in IDLE.
- gate_cycles  input  GATE_W  window length in clk cycles; latched when start is accepted.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse; count/overflow are valid and updated in this cycle.
- count  output  CNT_W  rising edges seen in the last window; holds until next done.
- overflow  output  1  last window saturated count; holds until next done.

Behaviour:
- Reset values: busy=0, done=0, count=0, overflow=0; FSM=IDLE; synchronizer and edge-history flops=0.
- Sync/edge detect:
  - osc_in passes through SYNC_STAGES flops giving s; a history flop p holds the previous s.
  - rise = s & ~p.
  - p updates every cycle in all states, so no spurious edge appears at window start.
- FSM states: IDLE, ARM, MEASURE, DONE.
- IDLE: start=1 -> latch gate_cycles into gate counter g, go to ARM. start=0 -> stay.
- ARM (1 cycle):
  - Clear accumulator acc and sticky ovf.
  - If g==0, go to DONE. Otherwise go to MEASURE.
- MEASURE:
  - Each cycle: if rise, acc increments, saturating at 2^CNT_W-1. A rise at saturation sets ovf.
  - g decrements by 1 each cycle; when g==1, go to DONE.
  - The window is exactly G cycles, and only rises in those cycles are counted.
- DONE (1 cycle): done=1, count<=acc, overflow<=ovf, then go to IDLE.
- Timing, with start accepted at edge t:
  - ARM at t+1.
  - MEASURE spans t+2 .. t+1+G.
  - done and busy-last at t+2+G.
  - For G=0, done at t+2.
- busy = (state != IDLE).
- start while busy is ignored, with no queuing. start held high continuously gives back-to-back measurements separated by one IDLE cycle.
- gate_cycles changes after acceptance have no effect on the current window.
- Reset mid-operation: immediate return to IDLE, outputs cleared, no done pulse.
- Frequency resolution: osc_in must be slower than clk/2 for an exact count; faster input under-counts, and this is the user's responsibility.

Decomposition:
- Package ring_meter_pkg:
  - state enum (IDLE, ARM, MEASURE, DONE).
  - Default-width localparams.
  - Saturation max constant function of CNT_W.
- Sub-module sync_edge_det (params SYNC_STAGES):
  - Inputs: clk, rst, async_in.
  - Outputs: level, rise.
  - Holds the synchronizer chain and edge history.
- Top holds the FSM, the gate counter and the accumulator.

Test Plan:
- osc_in toggles every 4 clk (period 8), gate_cycles=64, pulse start -> busy 1 for 66 cycles, done at t+66, count=8, overflow=0.
- osc_in held 0 (then held 1 in a second run), gate_cycles=100 -> count=0 both runs, done one cycle wide.
- gate_cycles=0, start -> done at t+2, count=0, overflow=0; previous nonzero count is overwritten.
- CNT_W=4, osc_in period 4 clk, gate_cycles=64 -> 16 rises, count=15, overflow=1. Follow-up run with gate_cycles=16 gives count=4, overflow=0.
- start pulsed again mid-MEASURE and gate_cycles changed to 8 -> ignored; original 64-cycle result unchanged, only one done.
- rst asserted asynchronously mid-MEASURE (between clk edges) -> busy=0, count=0, overflow=0 immediately, no done. A new start after release measures normally.
